// File: rtl/poly_ram.sv
// rtl/poly_ram.sv - coefficient RAM: one write port, two read ports, clear engine, out-of-range write flag
module poly_ram #(
  parameter int DATA_WIDTH = 13,
  parameter int ADDR_BITS  = 11,
  parameter int DEPTH      = 761,
  parameter int REG_OUT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  write_enable,
  input  logic [ADDR_BITS-1:0]  write_address,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic [ADDR_BITS-1:0]  read_address_a,
  output logic [DATA_WIDTH-1:0] output_data_a,
  input  logic [ADDR_BITS-1:0]  read_address_b,
  output logic [DATA_WIDTH-1:0] output_data_b,
  output logic                  oob_error
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [ADDR_BITS:0]   DEPTH_L = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST    = ADDR_BITS'(DEPTH - 1);

  state_t                state, state_next;
  logic [ADDR_BITS-1:0]  count, count_next;
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  logic                  in_range_w, in_range_a, in_range_b;
  logic                  start_ok, ext_ok, oob_hit;
  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  assign in_range_w = {1'b0, write_address}  < DEPTH_L;
  assign in_range_a = {1'b0, read_address_a} < DEPTH_L;
  assign in_range_b = {1'b0, read_address_b} < DEPTH_L;

  assign start_ok = (state == IDLE) && clear_start;
  assign ext_ok   = write_enable && (state != CLEAR) && in_range_w;
  assign oob_hit  = write_enable && (state != CLEAR) && !in_range_w;

  assign clear_busy = (state == CLEAR);
  assign clear_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: if (clear_start) begin
        state_next = CLEAR;
        count_next = '0;
      end
      CLEAR: if (count == LAST) begin
        state_next = DONE;
        count_next = '0;
      end else begin
        count_next = count + 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The clear engine owns the write port for its whole run; external writes are dropped.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = write_address;
    mem_data = input_data;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = count;
      mem_data = '0;
    end else if (ext_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        oob_error <= 1'b0;
    else if (oob_hit)  oob_error <= 1'b1;
    else if (start_ok) oob_error <= 1'b0;
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      // Write-first: a same-edge write to the read address is forwarded.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          output_data_a <= '0;
          output_data_b <= '0;
        end else begin
          output_data_a <= !in_range_a ? '0 :
                           (mem_we && mem_addr == read_address_a) ? mem_data : mem[read_address_a];
          output_data_b <= !in_range_b ? '0 :
                           (mem_we && mem_addr == read_address_b) ? mem_data : mem[read_address_b];
        end
      end
    end else begin : g_async
      assign output_data_a = in_range_a ? mem[read_address_a] : '0;
      assign output_data_b = in_range_b ? mem[read_address_b] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_poly_ram.sv
// tb/tb_poly_ram.sv - scoreboard bench for poly_ram, registered and asynchronous read builds side by side
module tb_poly_ram;

  localparam int DW    = 13;
  localparam int AW    = 11;
  localparam int DEPTH = 761;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_start;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] input_data;
  logic [AW-1:0] read_address_a, read_address_b;
  logic [DW-1:0] out_a_r, out_b_r, out_a_x, out_b_x;
  logic          busy_r, done_r, oob_r, busy_x, done_x, oob_x;

  int checks   = 0;
  int failures = 0;
  int mem_m [0:(1<<AW)-1];
  int q_a[$];
  int q_b[$];
  bit in_clear = 1'b0;

  always #5 clk = ~clk;

  poly_ram #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .DEPTH(DEPTH), .REG_OUT(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_busy(busy_r), .clear_done(done_r),
    .write_enable(write_enable), .write_address(write_address), .input_data(input_data),
    .read_address_a(read_address_a), .output_data_a(out_a_r),
    .read_address_b(read_address_b), .output_data_b(out_b_r), .oob_error(oob_r));

  poly_ram #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .DEPTH(DEPTH), .REG_OUT(0)) u_async (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_busy(busy_x), .clear_done(done_x),
    .write_enable(write_enable), .write_address(write_address), .input_data(input_data),
    .read_address_a(read_address_a), .output_data_a(out_a_x),
    .read_address_b(read_address_b), .output_data_b(out_b_x), .oob_error(oob_x));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int peek(input int a);
    return (a >= DEPTH) ? 0 : mem_m[a];
  endfunction

  // One clock: drive inputs, check async reads pre-edge, push registered expectations, pop after the edge.
  task automatic cyc(input bit we, input int wa, input int wd, input int ra, input int rb,
                     input bit cs, input bit chk);
    bit wr_ok;
    int ea, eb;
    write_enable   = we;
    write_address  = AW'(wa);
    input_data     = DW'(wd);
    read_address_a = AW'(ra);
    read_address_b = AW'(rb);
    clear_start    = cs;
    wr_ok = we && !in_clear && (wa < DEPTH);
    #1;
    if (chk) begin
      if (peek(ra) >= 0) check("async_a", out_a_x, peek(ra));
      if (peek(rb) >= 0) check("async_b", out_b_x, peek(rb));
    end
    ea = (ra >= DEPTH) ? 0 : (wr_ok && wa == ra) ? wd : mem_m[ra];
    eb = (rb >= DEPTH) ? 0 : (wr_ok && wa == rb) ? wd : mem_m[rb];
    if (chk) begin
      q_a.push_back(ea);
      q_b.push_back(eb);
    end
    if (wr_ok) mem_m[wa] = wd;
    @(posedge clk);
    #1;
    if (chk) begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      if (ea >= 0) check("reg_a", out_a_r, ea);
      if (eb >= 0) check("reg_b", out_b_r, eb);
    end
  endtask

  task automatic run_clear(input int abort_at);
    int n;
    n = 0;
    cyc(0, 0, 0, 0, 0, 1, 0);
    in_clear = 1'b1;
    check("busy_start", busy_r, 1);
    while (busy_r && n < 2000) begin
      n++;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_r, 0);
        check("abort_done", done_r, 0);
        check("abort_busy_x", busy_x, 0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < abort_at - 1; k++) mem_m[k] = 0;
        in_clear = 1'b0;
        return;
      end
      cyc(n == 5, 3, 13'h0555, 0, 0, 0, 0);
    end
    in_clear = 1'b0;
    check("busy_cycles", n, DEPTH);
    check("done_pulse", done_r, 1);
    check("done_pulse_x", done_x, 1);
    for (int k = 0; k < DEPTH; k++) mem_m[k] = 0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("done_drop", done_r, 0);
    check("busy_idle", busy_r, 0);
  endtask

  task automatic sweep(input int hi);
    for (int a = 0; a <= hi; a++) cyc(0, 0, 0, a, DEPTH - 1 - a, 0, 1);
  endtask

  task automatic fill();
    for (int a = 0; a < DEPTH; a++) cyc(1, a, a + 1, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < (1 << AW); k++) mem_m[k] = -1;
    rst_n = 1'b0; clear_start = 1'b0; write_enable = 1'b0;
    write_address = '0; input_data = '0; read_address_a = '0; read_address_b = '0;
    #12;
    check("rst_busy", busy_r, 0);
    check("rst_done", done_r, 0);
    check("rst_oob", oob_r, 0);
    check("rst_out_a", out_a_r, 0);
    check("rst_out_b", out_b_r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // write-first on both ports, then a plain registered read
    cyc(1, 5, 13'h1ABC, 5, 5, 0, 1);
    cyc(0, 0, 0, 5, 5, 0, 1);
    check("wf_a", out_a_r, 13'h1ABC);

    fill();
    sweep(DEPTH - 1);
    run_clear(-1);
    sweep(DEPTH - 1);
    check("mid_clear_write_dropped", out_b_r, 0);
    cyc(0, 0, 0, 3, 3, 0, 1);

    // top boundary and out-of-range write
    cyc(1, DEPTH - 1, 13'h0042, DEPTH - 1, 0, 0, 1);
    cyc(0, 0, 0, DEPTH - 1, DEPTH - 1, 0, 1);
    check("oob_before", oob_r, 0);
    cyc(1, DEPTH, 13'h0033, DEPTH, DEPTH, 0, 1);
    check("oob_set", oob_r, 1);
    check("oob_set_x", oob_x, 1);
    cyc(0, 0, 0, DEPTH, 2047, 0, 1);
    cyc(0, 0, 0, DEPTH - 1, DEPTH, 0, 1);
    check("oob_hold", oob_r, 1);
    run_clear(-1);
    check("oob_cleared", oob_r, 0);

    // clear aborted by reset partway through
    fill();
    run_clear(101);
    sweep(200);
    check("abort_addr200", out_a_r, 201);
    run_clear(-1);
    sweep(DEPTH - 1);

    // async build: old value before the edge, new right after, port B independent
    cyc(1, 10, 13'h0123, 0, 0, 0, 1);
    cyc(1, 9, 13'h0777, 9, 10, 0, 1);
    check("async_new_a", out_a_x, 13'h0777);
    check("async_b_10", out_b_x, 13'h0123);
    cyc(0, 0, 0, 9, 9, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
